// File: rtl/fifo_stat.sv
// fifo_stat: single-clock show-ahead FIFO with an entry counter, status
// flags and sticky overflow/underflow error flags. Depth does not have to
// be a power of two; both pointers wrap explicitly at g_depth-1.
module fifo_stat #(
   parameter int g_width    = 32,
   parameter int g_depth    = 16,
   parameter int g_af_level = g_depth - 2,
   parameter int g_ae_level = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [g_width-1:0]           data_i,
   input  logic                         push_i,
   input  logic                         pull_i,
   input  logic                         flush_i,
   input  logic                         clr_err_i,
   output logic [g_width-1:0]           data_o,
   output logic [$clog2(g_depth+1)-1:0] level_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic                         afull_o,
   output logic                         aempty_o,
   output logic                         ovf_o,
   output logic                         unf_o
);

   localparam int PW = (g_depth > 1) ? $clog2(g_depth) : 1;
   localparam int LW = $clog2(g_depth + 1);

   localparam logic [PW-1:0] PTR_LAST = PW'(g_depth - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(g_depth);
   localparam logic [LW-1:0] LVL_AF   = LW'(g_af_level);
   localparam logic [LW-1:0] LVL_AE   = LW'(g_ae_level);

   logic [g_width-1:0] mem [g_depth];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic               push_ok;
   logic               pull_ok;
   logic               ovf_set;
   logic               unf_set;

   // Pointer advance with explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      if (p == PTR_LAST) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   // Accept/error decode. A push on a full FIFO is still accepted when a pull
   // frees a slot in the same cycle; a pull on an empty FIFO accompanied by a
   // push is simply ignored (the push fills the FIFO) and is not an underflow.
   // Flush overrides everything, so it never raises an error flag.
   always_comb begin
      push_ok = push_i && (!full_o || pull_i);
      pull_ok = pull_i && !empty_o;
      ovf_set = push_i && full_o  && !pull_i && !flush_i;
      unf_set = pull_i && empty_o && !push_i && !flush_i;
   end

   // Storage array: never reset or flushed, validity comes from the pointers.
   always_ff @(posedge clk_i) begin
      if (push_ok && !flush_i) begin
         mem[wr_ptr] <= data_i;
      end
   end

   // Pointer and level registers; flush discards everything in one edge.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_o <= '0;
      end else if (flush_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_o <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (pull_ok) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         if (push_ok && !pull_ok) begin
            level_o <= level_o + 1'b1;
         end else if (pull_ok && !push_ok) begin
            level_o <= level_o - 1'b1;
         end
      end
   end

   // Sticky error flags; a new error in the same cycle wins over a clear.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ovf_o <= 1'b0;
         unf_o <= 1'b0;
      end else begin
         if (ovf_set) begin
            ovf_o <= 1'b1;
         end else if (clr_err_i) begin
            ovf_o <= 1'b0;
         end
         if (unf_set) begin
            unf_o <= 1'b1;
         end else if (clr_err_i) begin
            unf_o <= 1'b0;
         end
      end
   end

   // Status flags and show-ahead data, all decoded from registered state.
   always_comb begin
      full_o   = (level_o == LVL_FULL);
      empty_o  = (level_o == '0);
      afull_o  = (level_o >= LVL_AF);
      aempty_o = (level_o <= LVL_AE);
      data_o   = mem[rd_ptr];
   end

endmodule
